// File: rtl/sparse_vector_loader.sv
// Packs a stream of (A,B) element pairs into wide vectors with a per-lane nonzero mask.
// A fill buffer streams the next vector while the output register holds the current one.
module sparse_vector_loader #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned N_ELEM = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_a,
    input  logic [ELEM_W-1:0]        in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W*N_ELEM-1:0] Vector_A,
    output logic [ELEM_W*N_ELEM-1:0] Vector_B,
    output logic [N_ELEM-1:0]        nz_mask,
    output logic [CNT_W-1:0]         nz_count
);

    localparam int unsigned VEC_W = ELEM_W * N_ELEM;
    localparam int unsigned IDX_W = $clog2(N_ELEM);

    typedef enum logic {
        StFill,
        StFull
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [VEC_W-1:0]   fill_a;
    logic [VEC_W-1:0]   fill_b;
    logic [N_ELEM-1:0]  fill_mask;

    logic [VEC_W-1:0]   merged_a;
    logic [VEC_W-1:0]   merged_b;
    logic [N_ELEM-1:0]  merged_mask;
    logic [VEC_W-1:0]   xfer_a;
    logic [VEC_W-1:0]   xfer_b;
    logic [N_ELEM-1:0]  xfer_mask;
    logic [CNT_W-1:0]   xfer_count;

    logic slot_free;
    logic accept;
    logic completing;
    logic transfer;

    assign in_ready   = (state == StFill) && !rst;
    assign slot_free  = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign completing = accept && ((cnt == IDX_W'(N_ELEM - 1)) || in_last);
    assign transfer   = ((state == StFill) && completing && slot_free)
                      || ((state == StFull) && slot_free);

    // Unwritten lanes of the fill buffer are always zero, so merging is a plain lane write.
    always_comb begin
        merged_a              = fill_a;
        merged_b              = fill_b;
        merged_mask           = fill_mask;
        merged_a[ELEM_W*cnt +: ELEM_W] = in_a;
        merged_b[ELEM_W*cnt +: ELEM_W] = in_b;
        merged_mask[cnt]      = (in_a != '0) && (in_b != '0);
    end

    always_comb begin
        xfer_a     = (state == StFull) ? fill_a    : merged_a;
        xfer_b     = (state == StFull) ? fill_b    : merged_b;
        xfer_mask  = (state == StFull) ? fill_mask : merged_mask;
        xfer_count = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            xfer_count = xfer_count + CNT_W'(xfer_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StFill;
            cnt       <= '0;
            fill_a    <= '0;
            fill_b    <= '0;
            fill_mask <= '0;
            out_valid <= 1'b0;
            Vector_A  <= '0;
            Vector_B  <= '0;
            nz_mask   <= '0;
            nz_count  <= '0;
        end else if (transfer) begin
            Vector_A  <= xfer_a;
            Vector_B  <= xfer_b;
            nz_mask   <= xfer_mask;
            nz_count  <= xfer_count;
            out_valid <= 1'b1;
            fill_a    <= '0;
            fill_b    <= '0;
            fill_mask <= '0;
            cnt       <= '0;
            state     <= StFill;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if ((state == StFill) && accept) begin
                fill_a    <= merged_a;
                fill_b    <= merged_b;
                fill_mask <= merged_mask;
                if (completing) begin
                    // Output still occupied: park the finished vector until the slot frees.
                    state <= StFull;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end
        end
    end

endmodule
